latency_resp_gen: RTL and testbench
===================================

LATENCY_RESP_GEN -- requirements
Module: latency_resp_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 8, in-order queue entries (power of 2, 2..64).
REQ-002 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_pkt_valid  in  1  request packet valid.
REQ-005 SHALL have port req_pkt_marker  in  1  latency marker carried with the request.
REQ-006 SHALL have port req_pkt_tag  in  8  request identifier.
REQ-007 SHALL have port req_sink_rdy  out  1  block can accept a request.
REQ-008 SHALL have port resp_pkt_valid  out  1  response packet valid.
REQ-009 SHALL have port resp_sink_rdy  in  1  downstream accepts the response.
REQ-010 SHALL have port resp_pkt_marker  out  1  marker returned with the response.
REQ-011 SHALL have port resp_pkt_tag  out  8  tag returned with the response.
REQ-012 SHALL have port cfg_delay  in  8  response delay in cycles, sampled per request at accept.
REQ-013 SHALL have port occupancy  out  $clog2(DEPTH)+1  entries held.

Function
REQ-014 SHALL accept a request in any cycle where req_pkt_valid && req_sink_rdy, storing marker, tag and delay in the tail entry.
REQ-015 SHALL drive req_sink_rdy = (occupancy < DEPTH), registered-state only; no combinational path from resp_sink_rdy.
REQ-016 SHALL load each entry's countdown with its delay at accept; each occupied entry's countdown SHALL decrement by 1 per cycle, saturating at 0.
REQ-017 SHALL assert resp_pkt_valid when the queue is non-empty and the head countdown is 0. A request accepted in cycle T with delay D SHALL first show resp_pkt_valid in cycle T+1+D if it is head by then.
REQ-018 SHALL issue responses strictly in request order. A ripe non-head entry SHALL wait for the head to pop and then present in the next cycle at the earliest.
REQ-019 SHALL pop the head on resp_pkt_valid && resp_sink_rdy.
REQ-020 SHALL hold resp_pkt_valid, resp_pkt_marker and resp_pkt_tag stable while resp_pkt_valid && !resp_sink_rdy.
REQ-021 SHALL drive resp_pkt_marker and resp_pkt_tag to 0 whenever resp_pkt_valid is 0.
REQ-022 SHALL leave occupancy unchanged on a simultaneous push and pop. Push at full is impossible (req_sink_rdy low). Pop at empty is impossible (resp_pkt_valid low).
REQ-023 SHALL wrap read and write pointers modulo DEPTH. Occupancy SHALL distinguish full from empty.
REQ-024 SHALL pass the marker bit through unmodified, so it pairs with the latency monitor's marking of request/response packets.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-transfer, immediately clear all entries, pointers and countdowns. Reset values: occupancy=0, req_sink_rdy=1 (combinational from the cleared occupancy), resp_pkt_valid=0, resp_pkt_marker=0, resp_pkt_tag=0.
REQ-026 SHALL discard in-flight entries on reset; no response is issued for them after rst_n deasserts.
REQ-027 SHALL accept requests in the first rising edge after rst_n deasserts.

Configuration
REQ-028 SHALL recognise macro LATENCY_RESP_GEN_JITTER_EN.
REQ-029 With LATENCY_RESP_GEN_JITTER_EN defined:
- contains an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset value 8'hA5;
- LFSR advances once per accepted request;
- stored delay = min(255, cfg_delay + lfsr[1:0]), using the LFSR value before the advance.
REQ-030 Without LATENCY_RESP_GEN_JITTER_EN: no LFSR is present, and stored delay = cfg_delay exactly.

Verification
REQ-031 Single request: cfg_delay=5, resp_sink_rdy=1, accept at cycle 10 with marker=1, tag=8'h3C -> resp_pkt_valid only in cycle 16 with marker=1, tag=8'h3C; occupancy back to 0 in cycle 17.
REQ-032 Fill: DEPTH=8, resp_sink_rdy=0, 9 back-to-back requests -> first 8 accepted, req_sink_rdy low from the cycle after the 8th, occupancy=8.
REQ-033 Then pulse resp_sink_rdy for one cycle -> one pop, req_sink_rdy high next cycle, and the 9th request is accepted.
REQ-034 Ordering: request A with cfg_delay=20, then request B with cfg_delay=0 one cycle later -> B is not presented before A pops; tags emerge A then B.
REQ-035 Stall: head valid with resp_sink_rdy=0 for 50 cycles -> valid, marker and tag constant all 50 cycles; single pop on release.
REQ-036 Reset mid-operation: 4 entries queued, rst_n low for 1 cycle -> occupancy=0, resp_pkt_valid=0 immediately; no stale response afterwards.
REQ-037 Jitter build: cfg_delay=254 -> stored delay never exceeds 255. Without the macro: cfg_delay=0 gives 1-cycle latency for every request.

Source files
------------

// File: rtl/latency_resp_gen.sv
// latency_resp_gen: in-order request queue. Each request comes back as a
// response once its own delay has run out, and never before the requests
// accepted ahead of it have been returned.
// Optional build macro: LATENCY_RESP_GEN_JITTER_EN adds up to 3 cycles of
// LFSR-based jitter to each stored delay.
module latency_resp_gen #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_pkt_valid,
   input  logic                     req_pkt_marker,
   input  logic [7:0]               req_pkt_tag,
   output logic                     req_sink_rdy,
   output logic                     resp_pkt_valid,
   input  logic                     resp_sink_rdy,
   output logic                     resp_pkt_marker,
   output logic [7:0]               resp_pkt_tag,
   input  logic [7:0]               cfg_delay,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef struct packed {
      logic       marker;
      logic [7:0] tag;
      logic [7:0] cnt;
   } entry_t;

   entry_t            r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [OCC_W-1:0]  r_occ;

   logic              w_push;
   logic              w_pop;
   logic              w_head_ripe;
   logic [7:0]        w_delay;

`ifdef LATENCY_RESP_GEN_JITTER_EN
   logic [7:0]        r_lfsr;
   logic [8:0]        w_sum;

   // Jittered delay, saturated to 8 bits; uses the LFSR value before it advances.
   always_comb begin
      w_sum   = {1'b0, cfg_delay} + 9'(r_lfsr[1:0]);
      w_delay = w_sum[8] ? 8'hFF : w_sum[7:0];
   end

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 8'hA5;
      end else if (w_push) begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end
`else
   // Stored delay is the configured delay unchanged.
   always_comb begin
      w_delay = cfg_delay;
   end
`endif

   // Handshakes and head-of-queue outputs, all decoded from registered state.
   always_comb begin
      req_sink_rdy    = (r_occ < OCC_W'(DEPTH));
      w_head_ripe     = (r_mem[r_rd_ptr].cnt == 8'd0);
      resp_pkt_valid  = (r_occ != '0) && w_head_ripe;
      resp_pkt_marker = 1'b0;
      resp_pkt_tag    = 8'd0;
      if (resp_pkt_valid) begin
         resp_pkt_marker = r_mem[r_rd_ptr].marker;
         resp_pkt_tag    = r_mem[r_rd_ptr].tag;
      end
      w_push          = req_pkt_valid && req_sink_rdy;
      w_pop           = resp_pkt_valid && resp_sink_rdy;
      occupancy       = r_occ;
   end

   // Queue storage, countdowns, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         // Free-running saturating countdown; a slot is reloaded when it is written.
         for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].cnt != 8'd0) begin
               r_mem[i].cnt <= r_mem[i].cnt - 8'd1;
            end
         end
         if (w_push) begin
            r_mem[r_wr_ptr] <= '{marker: req_pkt_marker, tag: req_pkt_tag, cnt: w_delay};
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

endmodule

// File: tb/tb_latency_resp_gen.sv
// Scoreboard bench for latency_resp_gen: the stimulus side queues expected
// responses with the cycle they become due; the monitor checks the DUT every cycle.
module tb_latency_resp_gen;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_pkt_valid = 1'b0;
   logic        req_pkt_marker = 1'b0;
   logic [7:0]  req_pkt_tag = 8'd0;
   logic        req_sink_rdy;
   logic        resp_pkt_valid;
   logic        resp_sink_rdy = 1'b0;
   logic        resp_pkt_marker;
   logic [7:0]  resp_pkt_tag;
   logic [7:0]  cfg_delay = 8'd0;
   logic [$clog2(DEPTH):0] occupancy;

   latency_resp_gen #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_pkt_valid(req_pkt_valid), .req_pkt_marker(req_pkt_marker),
      .req_pkt_tag(req_pkt_tag), .req_sink_rdy(req_sink_rdy),
      .resp_pkt_valid(resp_pkt_valid), .resp_sink_rdy(resp_sink_rdy),
      .resp_pkt_marker(resp_pkt_marker), .resp_pkt_tag(resp_pkt_tag),
      .cfg_delay(cfg_delay), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] tag;
      logic       marker;
      int         acc;    // cycle in which the request was accepted
      int         due;    // first cycle the response may appear
   } exp_t;

   exp_t       q[$];
   int         cyc = 0;
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] m_lfsr = 8'hA5;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: delay as stored, then due cycle = accept + 1 + delay.
   task automatic model_push(input logic m, input logic [7:0] t, input logic [7:0] d);
      int eff;
      eff = int'(d);
`ifdef LATENCY_RESP_GEN_JITTER_EN
      eff = eff + int'(m_lfsr[1:0]);
      if (eff > 255) eff = 255;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
      q.push_back('{tag: t, marker: m, acc: cyc, due: cyc + 1 + eff});
   endtask

   // One cycle of stimulus; the request is modelled as accepted when the queue has room.
   task automatic drive(input logic v, input logic m, input logic [7:0] t,
                        input logic [7:0] d, input logic rr);
      @(posedge clk); #1;
      req_pkt_valid  = v;
      req_pkt_marker = m;
      req_pkt_tag    = t;
      cfg_delay      = d;
      resp_sink_rdy  = rr;
      if (v && q.size() < DEPTH) model_push(m, t, d);
   endtask

   task automatic idle(input int n, input logic rr);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'd0, 8'd0, rr);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 600) begin
         drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
         n++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   // Reset asserted mid-cycle for one cycle; a request is offered in the release cycle.
   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      req_pkt_valid = 1'b0;
      q.delete();
      m_lfsr = 8'hA5;
      @(posedge clk); #1;
      rst_n          = 1'b1;
      req_pkt_valid  = 1'b1;
      req_pkt_marker = 1'b1;
      req_pkt_tag    = 8'h77;
      cfg_delay      = 8'd0;
      resp_sink_rdy  = 1'b1;
      model_push(1'b1, 8'h77, 8'd0);
   endtask

   // Monitor: compare every cycle against the scoreboard, pop on handshake.
   always @(negedge clk) begin
      int  exp_occ;
      logic exp_valid;
      if (!rst_n) begin
         chk("rst_occupancy", int'(occupancy), 0);
         chk("rst_valid", int'(resp_pkt_valid), 0);
         chk("rst_tag", int'(resp_pkt_tag), 0);
         chk("rst_marker", int'(resp_pkt_marker), 0);
         chk("rst_req_rdy", int'(req_sink_rdy), 1);
      end else begin
         exp_occ = q.size();
         if (exp_occ > 0 && q[$].acc == cyc) exp_occ--;
         exp_valid = (exp_occ > 0) && (cyc >= q[0].due);
         chk("occupancy", int'(occupancy), exp_occ);
         chk("req_sink_rdy", int'(req_sink_rdy), (exp_occ < DEPTH) ? 1 : 0);
         chk("resp_valid", int'(resp_pkt_valid), int'(exp_valid));
         if (exp_valid) begin
            chk("resp_tag", int'(resp_pkt_tag), int'(q[0].tag));
            chk("resp_marker", int'(resp_pkt_marker), int'(q[0].marker));
            if (resp_sink_rdy) void'(q.pop_front());
         end else begin
            chk("idle_tag", int'(resp_pkt_tag), 0);
            chk("idle_marker", int'(resp_pkt_marker), 0);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3, 1'b1);

      // Single request, delay 5.
      drive(1'b1, 1'b1, 8'h3C, 8'd5, 1'b1);
      idle(10, 1'b1);

      // Fill with sink stalled, then one pop lets the 9th request in.
      for (int i = 0; i < 9; i++) drive(1'b1, 1'(i), 8'(8'h10 + i), 8'd0, 1'b0);
      drive(1'b1, 1'b0, 8'h18, 8'd0, 1'b1);
      drive(1'b1, 1'b0, 8'h18, 8'd0, 1'b0);
      drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      drain();

      // Ordering: long-delay A ahead of zero-delay B.
      drive(1'b1, 1'b0, 8'hAA, 8'd20, 1'b1);
      drive(1'b1, 1'b1, 8'hBB, 8'd0, 1'b1);
      drain();

      // Stall a ripe head for 50 cycles.
      drive(1'b1, 1'b1, 8'h5A, 8'd0, 1'b0);
      idle(50, 1'b0);
      drain();

      // Delay extremes.
      drive(1'b1, 1'b0, 8'hE1, 8'd254, 1'b1);
      drive(1'b1, 1'b1, 8'hE2, 8'd255, 1'b1);
      drain();
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 8'(8'h60 + i), 8'd0, 1'b1);
      drain();

      // Reset with four entries queued.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 8'(8'h40 + i), 8'd3, 1'b0);
      do_reset();
      drain();

      // Randomised traffic with occasional reset.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else begin
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 3)),
                  1'($urandom_range(0, 99) < 70));
         end
      end
      drain();
      idle(3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
